// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a single-outstanding OBI-style
// instruction port and buffers returned words with their PCs in a small prefetch FIFO.
module if_stage #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_enable_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic [1:0]  pc_mux_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] pc_id_o,
    output logic [1:0]  dbg_state_o
);

    // Memory handshake: a request transfers in the cycle where instr_req_o and
    // instr_gnt_i are both high; the response is the next instr_rvalid_i seen in WAIT.
    // Decode handshake: the FIFO head transfers when instr_valid_o and id_ready_i are high.

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [1:0] PC_INCR   = 2'b00;
    localparam logic [1:0] PC_JAL    = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_addr_q;
    logic [31:0]   req_addr_q;
    logic [31:0]   inflight_pc_q;
    logic          discard_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];

    logic          redirect;
    logic [31:0]   redirect_target;
    logic [31:0]   target_aligned;
    logic [CW:0]   occupancy;
    logic          space;
    logic          issue_idle;
    logic          gnt_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;

    assign redirect = (pc_mux_i != PC_INCR);

    always_comb begin
        redirect_target = BOOT_ADDR;
        case (pc_mux_i)
            PC_JAL:    redirect_target = jump_target_i;
            PC_BRANCH: redirect_target = branch_target_i;
            default:   redirect_target = BOOT_ADDR;
        endcase
    end

    assign target_aligned = {redirect_target[31:2], 2'b00};

    // A fetch in REQ or WAIT already owns a FIFO slot for its response.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, (state_q != S_IDLE)};
    assign space     = (32'(occupancy) < FIFO_DEPTH);

    assign issue_idle   = (state_q == S_IDLE) && fetch_enable_i && space && !redirect;
    assign instr_req_o  = issue_idle || (state_q == S_REQ);
    assign instr_addr_o = (state_q == S_REQ) ? req_addr_q : fetch_addr_q;
    assign gnt_fire     = instr_req_o && instr_gnt_i;
    assign resp_fire    = (state_q == S_WAIT) && instr_rvalid_i;

    assign push = resp_fire && !discard_q && !redirect;
    assign pop  = instr_valid_o && id_ready_i && !redirect;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue_idle) state_d = instr_gnt_i ? S_WAIT : S_REQ;
            S_REQ:   if (instr_gnt_i) state_d = S_WAIT;
            S_WAIT:  if (instr_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            fetch_addr_q  <= BOOT_ADDR;
            req_addr_q    <= BOOT_ADDR;
            inflight_pc_q <= 32'h0;
            discard_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // fetch_addr_q always names the next address to issue; a stalled
            // request keeps its own copy in req_addr_q so redirects cannot move it.
            if (issue_idle) begin
                fetch_addr_q <= fetch_addr_q + 32'd4;
                if (!instr_gnt_i) req_addr_q <= fetch_addr_q;
            end
            if (gnt_fire) inflight_pc_q <= instr_addr_o;
            if (resp_fire && discard_q) discard_q <= 1'b0;
            if (redirect) begin
                fetch_addr_q <= target_aligned;
                // A response landing in this same cycle is flushed anyway.
                if ((state_q == S_REQ) || ((state_q == S_WAIT) && !instr_rvalid_i))
                    discard_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= 32'h0;
                fifo_instr_q[i] <= 32'h0;
            end
        end else if (redirect) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
                fifo_instr_q[wr_ptr_q] <= instr_rdata_i;
                wr_ptr_q               <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_rdata_o = fifo_instr_q[rd_ptr_q];
    assign pc_id_o       = fifo_pc_q[rd_ptr_q];
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory responder, PC-stream reference model and scoreboard,
// directed scenarios followed by randomized traffic with redirects and resets.
module tb_if_stage;
    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        fetch_enable_i = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = 32'h0;
    logic [1:0]  pc_mux_i = 2'b00;
    logic [31:0] jump_target_i = 32'h0;
    logic [31:0] branch_target_i = 32'h0;
    logic        id_ready_i = 1'b0;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] pc_id_o;
    logic [1:0]  dbg_state_o;

    if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .fetch_enable_i(fetch_enable_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .pc_mux_i(pc_mux_i),
        .jump_target_i(jump_target_i), .branch_target_i(branch_target_i),
        .id_ready_i(id_ready_i), .instr_valid_o(instr_valid_o),
        .instr_rdata_o(instr_rdata_o), .pc_id_o(pc_id_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- reference model: PCs decode should see, in order ----------------
    logic [31:0] exp_q[$];
    int consumed = 0;
    int first_valid_cyc = -1;

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back(pc);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_restart(BOOT);
        first_valid_cyc = -1;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] tgt);
        pc_mux_i = sel;
        jump_target_i = tgt;
        branch_target_i = ~tgt;
        if (sel == 2'b10) branch_target_i = tgt;
        if (sel == 2'b10) jump_target_i = ~tgt;
        model_restart(sel == 2'b11 ? BOOT : {tgt[31:2], 2'b00});
        step();
        pc_mux_i = 2'b00;
    endtask

    // ---------------- memory responder ----------------
    bit          mem_rand = 1'b0;
    int          gnt_delay = 0;
    int          rlat = 0;
    bit          out_pend = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] resp_addr;
    bit          req_seen = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] req_addr_seen;
    logic [31:0] gnt_addr_q[$];
    int          gnt_cyc_q[$];

    always @(negedge clk_i) begin
        instr_rvalid_i = 1'b0;
        if (out_pend) begin
            if (lat_cnt == 0) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_data(resp_addr);
                out_pend       = 1'b0;
            end else lat_cnt--;
        end
        instr_gnt_i = 1'b0;
        if (rst_ni && instr_req_o) begin
            if (!req_seen) begin
                req_seen      = 1'b1;
                req_addr_seen = instr_addr_o;
                wait_cnt      = mem_rand ? $urandom_range(0, 3) : gnt_delay;
            end else check("addr_stable", instr_addr_o, req_addr_seen);
            if (wait_cnt == 0 && !out_pend && !instr_rvalid_i) begin
                instr_gnt_i = 1'b1;
                out_pend    = 1'b1;
                resp_addr   = instr_addr_o;
                lat_cnt     = mem_rand ? $urandom_range(0, 2) : rlat;
                req_seen    = 1'b0;
                gnt_addr_q.push_back(instr_addr_o);
                gnt_cyc_q.push_back(cyc);
            end else if (wait_cnt > 0) wait_cnt--;
        end else req_seen = 1'b0;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_i) begin
        logic [31:0] pc;
        if (rst_ni && instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (rst_ni && instr_valid_o && id_ready_i && pc_mux_i == 2'b00) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_empty: got pc %h with no expectation", pc_id_o);
            end else begin
                pc = exp_q.pop_front();
                check("pc_id", pc_id_o, pc);
                check("instr_rdata", instr_rdata_o, mem_data(pc));
                exp_q.push_back(pc + 32'd4);
                consumed++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int sz;
        int c0;
        bit found;
        model_restart(BOOT);

        // Reset values
        step();
        @(negedge clk_i);
        check("rst_req", {31'b0, instr_req_o}, 32'h0);
        check("rst_addr", instr_addr_o, BOOT);
        check("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        check("rst_rdata", instr_rdata_o, 32'h0);
        check("rst_pc", pc_id_o, 32'h0);
        check("rst_state", {30'b0, dbg_state_o}, 32'h0);
        step();

        // Zero-wait fetch: one request every 2 cycles, valid 2 cycles after first grant
        gnt_addr_q.delete(); gnt_cyc_q.delete();
        id_ready_i = 1'b1; fetch_enable_i = 1'b1; rst_ni = 1'b1;
        repeat (12) step();
        check("a_ngnt", {31'b0, gnt_addr_q.size() >= 3}, 32'h1);
        if (gnt_addr_q.size() >= 3) begin
            check("a_addr0", gnt_addr_q[0], 32'h0);
            check("a_addr1", gnt_addr_q[1], 32'h4);
            check("a_addr2", gnt_addr_q[2], 32'h8);
            check("a_spacing", 32'(gnt_cyc_q[1] - gnt_cyc_q[0]), 32'd2);
            check("a_latency", 32'(first_valid_cyc - gnt_cyc_q[0]), 32'd2);
        end

        // Decode stalled: exactly two entries buffered, then a single pop
        id_ready_i = 1'b0;
        rst_ni = 1'b0;
        model_restart(BOOT);
        first_valid_cyc = -1;
        step(); step();
        gnt_addr_q.delete(); gnt_cyc_q.delete();
        rst_ni = 1'b1;
        repeat (12) step();
        @(negedge clk_i);
        check("b_ngnt", 32'(gnt_addr_q.size()), 32'd2);
        check("b_valid", {31'b0, instr_valid_o}, 32'h1);
        check("b_head_pc", pc_id_o, 32'h0);
        check("b_no_req", {31'b0, instr_req_o}, 32'h0);
        step();
        id_ready_i = 1'b1;
        step();
        id_ready_i = 1'b0;
        repeat (6) step();
        @(negedge clk_i);
        check("b_ngnt2", 32'(gnt_addr_q.size()), 32'd3);
        if (gnt_addr_q.size() >= 3) check("b_addr2", gnt_addr_q[2], 32'h8);
        check("b_head_pc2", pc_id_o, 32'h4);
        step();

        // Grant delayed 3 cycles: address stability checked by the responder
        gnt_delay = 3; id_ready_i = 1'b1;
        c0 = consumed;
        repeat (40) step();
        check("c_progress", {31'b0, (consumed - c0) >= 5}, 32'h1);
        gnt_delay = 0;

        // JAL while WAIT: in-flight response dropped, next fetch from 0x100
        rlat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (dbg_state_o == 2'd2) found = 1'b1;
            else step();
        end
        check("d_wait_seen", {31'b0, found}, 32'h1);
        sz = gnt_addr_q.size();
        redirect(2'b01, 32'h0000_0100);
        @(negedge clk_i);
        check("d_flushed", {31'b0, instr_valid_o}, 32'h0);
        step();
        repeat (15) step();
        check("d_ngnt", {31'b0, gnt_addr_q.size() > sz}, 32'h1);
        if (gnt_addr_q.size() > sz) check("d_target_addr", gnt_addr_q[sz], 32'h100);
        rlat = 0;

        // BRANCH to unaligned target in IDLE: no request that cycle, then 0x200
        fetch_enable_i = 1'b0;
        repeat (10) step();
        fetch_enable_i = 1'b1;
        pc_mux_i = 2'b10; branch_target_i = 32'h0000_0203; jump_target_i = 32'h0;
        model_restart(32'h0000_0200);
        @(negedge clk_i);
        check("e_no_req", {31'b0, instr_req_o}, 32'h0);
        step();
        pc_mux_i = 2'b00;
        @(negedge clk_i);
        check("e_req", {31'b0, instr_req_o}, 32'h1);
        check("e_addr", instr_addr_o, 32'h200);
        step();
        repeat (10) step();

        // Address wrap at the top of the address space
        sz = gnt_addr_q.size();
        redirect(2'b01, 32'hFFFF_FFF8);
        repeat (20) step();
        found = 1'b0;
        for (int i = sz; i + 1 < gnt_addr_q.size(); i++) begin
            if (!found && gnt_addr_q[i] == 32'hFFFF_FFFC) begin
                found = 1'b1;
                check("f_wrap_addr", gnt_addr_q[i + 1], 32'h0);
            end
        end
        check("f_wrap_found", {31'b0, found}, 32'h1);

        // Randomized traffic with redirects and occasional mid-fetch resets
        mem_rand = 1'b1;
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            id_ready_i     = ($urandom_range(0, 3) != 0);
            fetch_enable_i = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 24) == 0)
                redirect(2'($urandom_range(1, 3)), $urandom);
            else if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                step();
        end
        check("g_progress", {31'b0, (consumed - c0) > 300}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch pipeline stage of the riscv_cpu core; sits directly upstream of id_stage and supplies its `instr_rdata_i`/`pc_id_i`. It owns the fetch PC, drives an OBI-style instruction memory port with at most one outstanding request, and buffers returned words in a 2-entry prefetch FIFO. It applies the `pc_mux_o` redirect produced by the decode stage by flushing buffered and in-flight fetches.

## Interface
- `BOOT_ADDR`, 32'h0000_0000: fetch PC after reset; also the PC_BOOT redirect target.
- `FIFO_DEPTH`, 2: prefetch entries; power of two, at least 2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `fetch_enable_i`  in  1  permits new memory requests.
- `instr_req_o`  out  1  memory request.
- `instr_addr_o`  out  32  request address, word aligned.
- `instr_gnt_i`  in  1  request accepted this cycle.
- `instr_rvalid_i`  in  1  response valid.
- `instr_rdata_i`  in  32  response data.
- `pc_mux_i`  in  2  redirect select: 00 PC_INCR (none), 01 PC_JAL, 10 PC_BRANCH, 11 PC_BOOT.
- `jump_target_i`  in  32  target for PC_JAL.
- `branch_target_i`  in  32  target for PC_BRANCH.
- `id_ready_i`  in  1  decode consumes the head instruction.
- `instr_valid_o`  out  1  FIFO head valid.
- `instr_rdata_o`  out  32  head instruction.
- `pc_id_o`  out  32  PC of head instruction.

## Operation
- FSM states IDLE, REQ, WAIT; plus `fetch_addr` (32), `discard` flag, FIFO of {pc, instr}, occupancy count.
- `space` = (count + (state != IDLE)) < FIFO_DEPTH.
- `instr_req_o` = (IDLE and fetch_enable_i and space and pc_mux_i == PC_INCR) or REQ. `instr_addr_o` = `fetch_addr`; held stable while REQ.
- IDLE: req asserted with gnt -> WAIT; without gnt -> REQ. REQ: gnt -> WAIT. WAIT: rvalid -> IDLE.
- On gnt: latch issued address as in-flight PC; `fetch_addr` += 4 (modulo 2^32, 0xFFFF_FFFC wraps to 0).
- On rvalid in WAIT with `discard` clear: push {in-flight PC, instr_rdata_i}. With `discard` set: drop, clear `discard`. rvalid in IDLE/REQ ignored.
- Pop when `instr_valid_o` and `id_ready_i`. Push and pop in the same cycle allowed; push never occurs when full (guaranteed by `space`).
- Redirect (pc_mux_i != PC_INCR), any cycle: FIFO flushed (count = 0, flush overrides same-cycle pop/push); `fetch_addr` <= target with bits [1:0] forced to 0; if state is REQ or WAIT, `discard` set (REQ keeps its original address until granted, response dropped). Redirect wins over the +4 update on a same-cycle gnt.
- fetch_enable_i low: no new requests; an outstanding REQ/WAIT completes; FIFO keeps draining.

## Timing
- Reset: `instr_req_o`=0, `instr_addr_o`=BOOT_ADDR, `instr_valid_o`=0, `instr_rdata_o`=0, `pc_id_o`=0, state IDLE, `discard`=0, count 0.
- `instr_valid_o`, `instr_rdata_o`, `pc_id_o` come from FIFO registers only; no combinational path from memory inputs or `id_ready_i`.
- Latency: req+gnt in cycle N, rvalid in N+1 -> `instr_valid_o` high in N+2.
- Throughput: one fetch per 2 cycles with zero-wait memory (new request issued from IDLE only).
- Redirect in cycle N: `instr_valid_o` low in N+1; with state IDLE at N, request to target issued in N+1.
- Reset mid-fetch: all state cleared immediately; late rvalid after reset ignored (state IDLE).

## Test plan
- Reset release, fetch_enable_i=1, zero-wait memory returning addr-derived data -> requests to 0x0, 0x4, 0x8 every 2 cycles; first `instr_valid_o` 2 cycles after first gnt with `pc_id_o`=0x0.
- id_ready_i=0 -> exactly 2 entries (0x0, 0x4) buffered, no third request; id_ready_i=1 for one cycle -> one pop, next request at 0x8.
- gnt delayed 3 cycles -> `instr_addr_o` stable during REQ, PC sequence unbroken.
- PC_JAL to 0x100 while WAIT -> FIFO flushed, in-flight response dropped, next request 0x100, next `pc_id_o`=0x100.
- PC_BRANCH to 0x203 in IDLE -> no request that cycle, next request address 0x200.
- `fetch_addr` = 0xFFFF_FFFC, granted -> next request address 0x0.
